latch_bank_write_ctrl: RTL

//  Sequences writes into a bank of DEPTH d_latch words shared by NREQ requesters.

---
 rtl/latch_bank_write_ctrl_pkg.sv | 15 +
 rtl/latch_bank_write_ctrl_rr_arbiter.sv | 31 +++
 rtl/latch_bank_write_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/latch_bank_write_ctrl_pkg.sv
// Shared definitions for the latch bank write controller: FSM encoding and stats width.
// Optional write counter is enabled with LATCH_CTRL_STATS_EN.
package latch_bank_write_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_OPEN  = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   localparam int STATS_W = 16;

endpackage

// File: rtl/latch_bank_write_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set req bit at or above ptr,
// wrapping modulo NREQ. The caller registers the result.
module latch_bank_write_ctrl_rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   win_id
);

   int  idx;
   logic found;

   always_comb begin
      grant  = '0;
      win_id = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            win_id     = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/latch_bank_write_ctrl.sv
// Round-robin write sequencer for a level-sensitive latch bank (setup/open/hold on En).
// Define LATCH_CTRL_STATS_EN to add the wr_count successful-write counter.
module latch_bank_write_ctrl
   import latch_bank_write_ctrl_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int W         = 8,
   parameter int DEPTH     = 4,
   parameter int AW        = 2,
   parameter int EN_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*W-1:0]    req_data,
   output logic [NREQ-1:0]      gnt,
   output logic                 err,
   output logic                 busy,
   output logic [W-1:0]         lat_d,
   output logic [DEPTH-1:0]     lat_en,
`ifdef LATCH_CTRL_STATS_EN
   output logic [STATS_W-1:0]   wr_count,
`endif
   output logic [2:0]           dbg_state
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

   state_e            state_q;
   logic [IW-1:0]     rr_ptr_q, win_id_q, arb_win;
   logic [NREQ-1:0]   arb_gnt, win_oh_q, gnt_q;
   logic [AW-1:0]     addr_q, arb_addr;
   logic [W-1:0]      lat_d_q, arb_data;
   logic [DEPTH-1:0]  lat_en_q, en_onehot_d;
   logic [CW-1:0]     cnt_q;
   logic              err_q, busy_q, addr_bad_d;
`ifdef LATCH_CTRL_STATS_EN
   logic [STATS_W-1:0] wr_count_q;
   assign wr_count = wr_count_q;
`endif

   latch_bank_write_ctrl_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req    (req),
      .ptr    (rr_ptr_q),
      .grant  (arb_gnt),
      .win_id (arb_win)
   );

   assign arb_addr = req_addr[int'(arb_win)*AW +: AW];
   assign arb_data = req_data[int'(arb_win)*W +: W];

   // Out-of-range addresses decode to no enable at all, so the bank is never touched.
   always_comb begin
      addr_bad_d  = (int'(addr_q) >= DEPTH);
      en_onehot_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
         en_onehot_d[k] = (int'(addr_q) == k);
      end
   end

   // lat_d_q doubles as the captured data register; it only changes on IDLE->SETUP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         win_id_q <= '0;
         win_oh_q <= '0;
         addr_q   <= '0;
         cnt_q    <= '0;
         gnt_q    <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         lat_d_q  <= '0;
         lat_en_q <= '0;
`ifdef LATCH_CTRL_STATS_EN
         wr_count_q <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (|req) begin
                  win_id_q <= arb_win;
                  win_oh_q <= arb_gnt;
                  addr_q   <= arb_addr;
                  lat_d_q  <= arb_data;
                  busy_q   <= 1'b1;
                  state_q  <= S_SETUP;
               end
            end
            S_SETUP: begin
               lat_en_q <= en_onehot_d;
               cnt_q    <= CW'(EN_CYCLES - 1);
               state_q  <= S_OPEN;
            end
            S_OPEN: begin
               if (cnt_q == '0) begin
                  lat_en_q <= '0;
                  state_q  <= S_HOLD;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_HOLD: begin
               gnt_q    <= win_oh_q;
               err_q    <= addr_bad_d;
               rr_ptr_q <= (int'(win_id_q) == NREQ - 1) ? '0 : win_id_q + 1'b1;
               state_q  <= S_DONE;
            end
            S_DONE: begin
               gnt_q   <= '0;
               err_q   <= 1'b0;
               busy_q  <= 1'b0;
`ifdef LATCH_CTRL_STATS_EN
               if (!err_q) wr_count_q <= wr_count_q + 1'b1;
`endif
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign err       = err_q;
   assign busy      = busy_q;
   assign lat_d     = lat_d_q;
   assign lat_en    = lat_en_q;
   assign dbg_state = state_q;

endmodule
